disp_scan_mux: RTL and testbench
================================

Name: disp_scan_mux

Overview:
Time-multiplexed scanner for a common-anode multi-digit 7-segment display. Sits directly upstream of the BCD-to-7-segment decoder.
- Holds N_DIGITS BCD digits.
- Drives one 4-bit digit code at a time into the decoder.
- Asserts the matching digit enable.
- Inserts a dead-time gap between digits against ghosting.
- New values are loaded via a pulse and applied only at frame boundaries, so no tearing.

Parameters:
N_DIGITS, 4, number of digits scanned (1..8).
ON_CYC, 50000, clk cycles each digit is lit (>=1).
GAP_CYC, 500, clk cycles all digits are dark between digits (>=1).

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
load  input  1  one-cycle strobe; data_in is captured when high.
data_in  input  4*N_DIGITS  BCD digits; [3:0] = digit 0 (least significant / rightmost).
digit_code  output  4  BCD code to the decoder; 4'hF = blank (the decoder outputs all-off for codes >9).
an  output  N_DIGITS  digit enables, active-low, at most one low at a time.
frame_done  output  1  one-cycle pulse when the last digit's gap ends.
pending  output  1  high while a loaded value waits for the frame boundary.

Behaviour:
Clock and reset:
- Single clock: clk.
- Reset is synchronous and active-high on rst.

Reset values:
- digit_code = 4'hF; an = all 1s.
- frame_done = 0; pending = 0.
- Digit index idx = 0; state = ST_ON.
- Cycle counter = 0.
- Active and shadow registers = all 4'hF.

States:
- ST_ON:
  - an[idx] = 0; digit_code = active[idx].
  - Counter runs 0..ON_CYC-1; at ON_CYC-1 go to ST_GAP with counter = 0.
- ST_GAP:
  - an = all 1s; digit_code = 4'hF.
  - Counter runs 0..GAP_CYC-1; at GAP_CYC-1 go to ST_ON with counter = 0.
  - idx increments and wraps from N_DIGITS-1 to 0.

Output timing:
- Outputs are registered and change on the clk edge that enters the state.
- The first ST_ON after reset shows digit 0 (blank) for ON_CYC cycles.

Frame boundary:
- The boundary is the ST_GAP exit with idx = N_DIGITS-1.
- On that edge: frame_done = 1 for one cycle.
- If pending = 1: active <= shadow and pending <= 0.

Load:
- load = 1: shadow <= data_in, pending <= 1.
- Repeated loads before a boundary overwrite shadow; last one wins.
- load coincident with the boundary edge: active <= data_in directly, pending stays 0, shadow <= data_in.

Other rules:
- BCD codes 10..14 pass through unchanged; the decoder blanks them.
- rst asserted mid-scan forces all reset values on the next edge; any pending load is discarded.
- No counter overflow is permitted: counter width is clog2(max(ON_CYC, GAP_CYC)).

Optional Feature:
DISP_SCAN_LZB_EN (leading-zero blanking).
- Defined: when digit_code is driven in ST_ON, any digit equal to 0 whose all higher-index digits are also 0 is output as 4'hF. Digit 0 is never blanked, so value 0 shows "0".
  - Enable timing is unchanged; an still pulses low for blanked digits.
- Undefined: all digits are shown as stored.

Decomposition:
Package disp_pkg:
- State encoding ST_ON = 1'b0, ST_GAP = 1'b1.
- BLANK_CODE = 4'hF.
- Function clog2 for counter sizing.

Sub-module scan_timer:
- Parameterized down-counter with load value and terminal-count output.
- Instantiated once, reloaded with ON_CYC-1 or GAP_CYC-1 per state.
- All other logic stays in the top module.

Test Plan:
(N_DIGITS=4, ON_CYC=4, GAP_CYC=2 unless stated.)
- Reset: hold rst 3 cycles -> digit_code = 4'hF, an = 4'b1111, frame_done = 0, pending = 0. First edge after release -> an = 4'b1110 for 4 cycles, then 4'b1111 for 2 cycles.
- Load 16'h1234 mid-frame -> pending = 1 until the boundary. Next frame shows 4, 3, 2, 1 on an = 1110, 1101, 1011, 0111. frame_done pulses every 24 cycles.
- Two loads, 16'h1111 then 16'h9876, in one frame -> only 9876 is displayed; 1111 never appears.
- Load 16'h0505 on the exact boundary edge -> the next ST_ON shows digit 5 immediately; pending stays 0.
- rst asserted in ST_ON of digit 2 with pending = 1 -> next edge: all reset values, and the pending value is lost.
- DISP_SCAN_LZB_EN defined:
  - Load 16'h0040 -> codes 0, 4, F, F.
  - Load 16'h0000 -> codes 0, F, F, F.
  - Macro undefined, 16'h0040 -> codes 0, 4, 0, 0.

Source files
------------

// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the multiplexed 7-segment display scanner.
//   state_t    : scan phase encoding (digit lit / inter-digit dead time)
//   BLANK_CODE : code that the downstream BCD decoder renders as all-off
//   clog2      : ceiling log2 used to size counters and indices
// -----------------------------------------------------------------------------
package disp_pkg;

   typedef enum logic {
      ST_ON  = 1'b0,
      ST_GAP = 1'b1
   } state_t;

   localparam logic [3:0] BLANK_CODE = 4'hF;

   // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/disp_scan_mux_scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Loadable down-counter that times the lit and dark phases of the scanner.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset, clears the count to 0
//   load     : reload the counter with load_val on this edge
//   load_val : value loaded; the phase then lasts load_val+1 cycles
//   tc       : terminal count, high while the count is 0
// -----------------------------------------------------------------------------
module scan_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         // Holds at zero rather than wrapping if nobody reloads it.
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/disp_scan_mux.sv
// -----------------------------------------------------------------------------
// disp_scan_mux
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Presents one BCD digit at a time to the downstream decoder with its
// active-low anode enable, separated by an all-dark dead time. New display
// values are staged in a shadow register and only take effect at the end of
// a complete frame, so a frame never mixes old and new digits.
//
// Build option: define DISP_SCAN_LZB_EN to blank leading zeros (digit 0 is
// always shown). Without it every digit is shown as stored.
//
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset
//   load       : one-cycle strobe capturing data_in
//   data_in    : 4*N_DIGITS BCD digits, [3:0] is digit 0 (rightmost)
//   digit_code : BCD code to the decoder, 4'hF = blank
//   an         : active-low digit enables, at most one low
//   frame_done : one-cycle pulse when the last digit's dead time ends
//   pending    : a loaded value is waiting for the frame boundary
// -----------------------------------------------------------------------------
module disp_scan_mux
   import disp_pkg::*;
#(
   parameter int N_DIGITS = 4,
   parameter int ON_CYC   = 50000,
   parameter int GAP_CYC  = 500
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*N_DIGITS-1:0]   data_in,
   output logic [3:0]              digit_code,
   output logic [N_DIGITS-1:0]     an,
   output logic                    frame_done,
   output logic                    pending
);

   localparam int DW      = 4 * N_DIGITS;
   localparam int MAX_CYC = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
   localparam int CNT_W   = (clog2(MAX_CYC) < 1) ? 1 : clog2(MAX_CYC);
   localparam int IDX_W   = (clog2(N_DIGITS) < 1) ? 1 : clog2(N_DIGITS);

   localparam logic [CNT_W-1:0]    ON_LOAD  = CNT_W'(ON_CYC - 1);
   localparam logic [CNT_W-1:0]    GAP_LOAD = CNT_W'(GAP_CYC - 1);
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] AN_ONE   = N_DIGITS'(1);

   // Code shown for digit i of the given value set.
   function automatic logic [3:0] digit_at(input logic [DW-1:0]    vals,
                                           input logic [IDX_W-1:0] i);
      logic [3:0] code;
`ifdef DISP_SCAN_LZB_EN
      logic       all_zero;
`endif
      code = vals[int'(i)*4 +: 4];
`ifdef DISP_SCAN_LZB_EN
      // A zero is a leading zero when it and every higher digit are zero.
      // Digit 0 is exempt so an all-zero value still reads "0".
      if (i != '0) begin
         all_zero = 1'b1;
         for (int k = 0; k < N_DIGITS; k++) begin
            if ((k >= int'(i)) && (vals[k*4 +: 4] != 4'd0)) begin
               all_zero = 1'b0;
            end
         end
         if (all_zero) begin
            code = BLANK_CODE;
         end
      end
`endif
      return code;
   endfunction

   // Registered state
   state_t               state_q,      state_d;
   logic [IDX_W-1:0]     idx_q,        idx_d;
   logic                 run_q,        run_d;
   logic [DW-1:0]        active_q,     active_d;
   logic [DW-1:0]        shadow_q,     shadow_d;
   logic                 pending_q,    pending_d;
   logic [3:0]           code_q,       code_d;
   logic [N_DIGITS-1:0]  an_q,         an_d;
   logic                 frame_done_q, frame_done_d;

   // Timer control and decoded events
   logic                 tmr_load;
   logic [CNT_W-1:0]     tmr_val;
   logic                 tmr_tc;
   logic                 enter_on;
   logic                 boundary;

   scan_timer #(
      .W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      run_d        = 1'b1;
      active_d     = active_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      code_d       = code_q;
      an_d         = an_q;
      frame_done_d = 1'b0;
      tmr_load     = 1'b0;
      tmr_val      = ON_LOAD;
      enter_on     = 1'b0;
      boundary     = 1'b0;

      if (!run_q) begin
         // Reset leaves the outputs dark; the first edge afterwards enters
         // the lit phase of digit 0 with a full ON period ahead of it.
         tmr_load = 1'b1;
         tmr_val  = ON_LOAD;
         enter_on = 1'b1;
      end else if (tmr_tc) begin
         if (state_q == ST_ON) begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
            code_d   = BLANK_CODE;
            an_d     = '1;
         end else begin
            state_d  = ST_ON;
            tmr_load = 1'b1;
            tmr_val  = ON_LOAD;
            enter_on = 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d    = '0;
               boundary = 1'b1;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
      end

      // A load landing on the boundary edge goes straight to the display;
      // otherwise it is staged and committed at the next boundary.
      if (boundary) begin
         frame_done_d = 1'b1;
         pending_d    = 1'b0;
         if (load) begin
            active_d = data_in;
            shadow_d = data_in;
         end else if (pending_q) begin
            active_d = shadow_q;
         end
      end else if (load) begin
         shadow_d  = data_in;
         pending_d = 1'b1;
      end

      // Use the post-commit value so the first digit of a new frame already
      // shows the new data.
      if (enter_on) begin
         code_d = digit_at(active_d, idx_d);
         an_d   = ~(AN_ONE << idx_d);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_ON;
         idx_q        <= '0;
         run_q        <= 1'b0;
         active_q     <= {N_DIGITS{BLANK_CODE}};
         shadow_q     <= {N_DIGITS{BLANK_CODE}};
         pending_q    <= 1'b0;
         code_q       <= BLANK_CODE;
         an_q         <= '1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         run_q        <= run_d;
         active_q     <= active_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         code_q       <= code_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign digit_code = code_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;
   assign pending    = pending_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_disp_scan_mux
// Self-checking bench for disp_scan_mux with N_DIGITS=4, ON_CYC=4, GAP_CYC=2.
// A table of load vectors gives the digit codes expected in the frame after
// each load; these are queued per frame/digit and compared whenever a digit
// lights up. Hand-written sequences cover reset, the boundary-edge load and
// reset during a pending load.
// -----------------------------------------------------------------------------
module tb_disp_scan_mux;

   localparam int N_DIGITS = 4;
   localparam int ON_CYC   = 4;
   localparam int GAP_CYC  = 2;
   localparam int FRAME    = N_DIGITS * (ON_CYC + GAP_CYC);

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] data_in;
   logic [3:0]  digit_code;
   logic [3:0]  an;
   logic        frame_done;
   logic        pending;

   disp_scan_mux #(
      .N_DIGITS (N_DIGITS),
      .ON_CYC   (ON_CYC),
      .GAP_CYC  (GAP_CYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .data_in    (data_in),
      .digit_code (digit_code),
      .an         (an),
      .frame_done (frame_done),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard of expected lit digits
   typedef struct {
      int         frame;
      int         digit;
      logic [3:0] an;
      logic [3:0] code;
   } sb_t;

   sb_t        sb_q[$];
   logic [3:0] an_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   task automatic push_frame(input int f, input logic [15:0] codes);
      sb_t e;
      for (int d = 0; d < 4; d++) begin
         e.frame = f;
         e.digit = d;
         e.an    = an_pat[d];
         e.code  = codes[d*4 +: 4];
         sb_q.push_back(e);
      end
   endtask

   // Monitor: every new lit digit is matched against the scoreboard.
   int   lit_cnt   = 0;
   logic prev_dark = 1'b1;

   always @(negedge clk) begin
      sb_t e;
      if (rst) begin
         lit_cnt   = 0;
         prev_dark = 1'b1;
      end else begin
         check("an_at_most_one_low", 32'($countones(~an) <= 1), 32'd1);
         if (an != 4'hF) begin
            if (prev_dark) begin
               while (sb_q.size() > 0 && (sb_q[0].frame * 4 + sb_q[0].digit) < lit_cnt) begin
                  e = sb_q.pop_front();
                  check("sb_digit_missed", 32'(e.frame * 4 + e.digit), 32'(lit_cnt));
               end
               if (sb_q.size() > 0 && (sb_q[0].frame * 4 + sb_q[0].digit) == lit_cnt) begin
                  e = sb_q.pop_front();
                  check($sformatf("sb_f%0d_d%0d_an", e.frame, e.digit), 32'(an), 32'(e.an));
                  check($sformatf("sb_f%0d_d%0d_code", e.frame, e.digit), 32'(digit_code), 32'(e.code));
               end
               lit_cnt++;
            end
            prev_dark = 1'b0;
         end else begin
            prev_dark = 1'b1;
         end
      end
   end

   int frame_idx;
   int last_bnd;
   bit last_bnd_valid;

   // Advance to the next frame_done pulse (bounded) and check the period.
   task automatic wait_boundary();
      int n;
      n = 0;
      tick(1);
      while (frame_done !== 1'b1 && n < 2 * FRAME) begin
         tick(1);
         n++;
      end
      check("frame_done_seen", 32'(frame_done), 32'd1);
      if (last_bnd_valid) check("frame_period", 32'(cyc - last_bnd), 32'(FRAME));
      last_bnd       = cyc;
      last_bnd_valid = 1'b1;
      frame_idx++;
   endtask

   typedef struct {
      string       name;
      logic        has_pre;
      logic [15:0] pre;
      logic [15:0] data;
      logic [15:0] exp;   // exp[3:0] = code expected on digit 0
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{"ld_1234",      1'b0, 16'h0000, 16'h1234, 16'h1234};
      vecs[1] = '{"ld_1111_9876", 1'b1, 16'h1111, 16'h9876, 16'h9876};
`ifdef DISP_SCAN_LZB_EN
      vecs[2] = '{"ld_0040",      1'b0, 16'h0000, 16'h0040, 16'hFF40};
      vecs[3] = '{"ld_0000",      1'b0, 16'h0000, 16'h0000, 16'hFFF0};
`else
      vecs[2] = '{"ld_0040",      1'b0, 16'h0000, 16'h0040, 16'h0040};
      vecs[3] = '{"ld_0000",      1'b0, 16'h0000, 16'h0000, 16'h0000};
`endif
      vecs[4] = '{"ld_a0ce",      1'b0, 16'h0000, 16'hA0CE, 16'hA0CE};

      rst            = 1'b1;
      load           = 1'b0;
      data_in        = 16'h0000;
      frame_idx      = 0;
      last_bnd       = 0;
      last_bnd_valid = 1'b0;

      // Reset values after three reset cycles
      tick(3);
      check("rst_code", 32'(digit_code), 32'hF);
      check("rst_an", 32'(an), 32'hF);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);

      // First frame shows blank digits; digit 0 lit 4 cycles, then 2 dark
      push_frame(0, 16'hFFFF);
      rst = 1'b0;
      for (int i = 0; i < ON_CYC + GAP_CYC; i++) begin
         tick(1);
         check($sformatf("first_digit_an_c%0d", i), 32'(an), (i < ON_CYC) ? 32'hE : 32'hF);
      end

      // Table of loads, each shown in the frame after it
      for (int i = 0; i < 5; i++) begin
         tick(3);
         if (vecs[i].has_pre) begin
            load    = 1'b1;
            data_in = vecs[i].pre;
            tick(1);
         end
         load    = 1'b1;
         data_in = vecs[i].data;
         tick(1);
         load = 1'b0;
         check({vecs[i].name, "_pending_set"}, 32'(pending), 32'd1);
         push_frame(frame_idx + 1, vecs[i].exp);
         wait_boundary();
         check({vecs[i].name, "_pending_clr"}, 32'(pending), 32'd0);
      end

      // Load coincident with the boundary edge
      tick(FRAME - 1);
`ifdef DISP_SCAN_LZB_EN
      push_frame(frame_idx + 1, 16'hF505);
`else
      push_frame(frame_idx + 1, 16'h0505);
`endif
      load    = 1'b1;
      data_in = 16'h0505;
      tick(1);
      load = 1'b0;
      check("bnd_load_frame_done", 32'(frame_done), 32'd1);
      check("bnd_load_pending", 32'(pending), 32'd0);
      check("bnd_load_code", 32'(digit_code), 32'h5);
      check("bnd_load_an", 32'(an), 32'hE);
      check("bnd_load_period", 32'(cyc - last_bnd), 32'(FRAME));
      last_bnd = cyc;
      frame_idx++;
      wait_boundary();
      check("sb_drained_before_rst", 32'(sb_q.size()), 32'd0);

      // Reset during digit 2 with a load pending: the load is discarded
      tick(2);
      load    = 1'b1;
      data_in = 16'h7777;
      tick(1);
      load = 1'b0;
      check("mid_rst_pending_set", 32'(pending), 32'd1);
      tick(9);
      check("mid_rst_digit2_an", 32'(an), 32'hB);
      rst = 1'b1;
      tick(1);
      check("mid_rst_code", 32'(digit_code), 32'hF);
      check("mid_rst_an", 32'(an), 32'hF);
      check("mid_rst_pending", 32'(pending), 32'd0);
      check("mid_rst_frame_done", 32'(frame_done), 32'd0);
      tick(2);
      push_frame(0, 16'hFFFF);
      frame_idx      = 0;
      last_bnd_valid = 1'b0;
      rst            = 1'b0;
      wait_boundary();
      check("post_rst_pending", 32'(pending), 32'd0);
      tick(2);
      check("sb_drained_end", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
